// File: rtl/cve2_rvfi_trace_packer_pkg.sv
// ----------------------------------------------------------------------------
// cve2_rvfi_trace_packer_pkg
//   Shared types for the RVFI trace packer: the packed header word, the
//   128-bit stored record, the beat/FSM state enum and a helper that picks
//   the 32-bit payload belonging to a given beat of a record.
// ----------------------------------------------------------------------------
package cve2_rvfi_trace_packer_pkg;

  localparam int unsigned TraceBeatsPerRec = 4;
  localparam int unsigned DropPendW        = 5;

  // Beat sequence of one packet; IDLE means no beat is being offered.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    PC    = 3'd2,
    INSN  = 3'd3,
    WDATA = 3'd4
  } trace_beat_e;

  // First beat of every packet, MSB first.
  typedef struct packed {
    logic                 trap;
    logic                 intr;
    logic                 halt;
    logic                 ovf;        // records were lost before this one
    logic [4:0]           rd_addr;
    logic [1:0]           mode;
    logic [DropPendW-1:0] drop_pend;  // how many were lost (saturating)
    logic [15:0]          order;
  } trace_hdr_t;

  // One FIFO entry; field order matches the beat order on the wire.
  typedef struct packed {
    trace_hdr_t  hdr;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wdata;
  } trace_rec_t;

  // Payload of one beat of a record; IDLE yields zero so the idle bus is clean.
  function automatic logic [31:0] beat_word(input trace_rec_t rec, input trace_beat_e beat);
    logic [31:0] word;
    word = '0;
    case (beat)
      HDR:     word = rec.hdr;
      PC:      word = rec.pc;
      INSN:    word = rec.insn;
      WDATA:   word = rec.wdata;
      default: word = '0;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/cve2_trace_fifo.sv
// ----------------------------------------------------------------------------
// cve2_trace_fifo
//   Synchronous FIFO of Depth entries, Width bits each. The head entry and
//   the entry behind it are both visible so the consumer can load its next
//   record in the same cycle it pops the current one. Push and pop in the
//   same cycle are legal even when full (the written slot is the one being
//   vacated).
// Ports
//   clk, rst     clock, synchronous active-high reset
//   push, wdata  write strobe and data
//   pop          remove the head entry
//   rdata        head entry
//   rdata_next   entry behind the head (valid when level >= 2)
//   full, empty  occupancy flags
//   level        number of entries held
// ----------------------------------------------------------------------------
module cve2_trace_fifo #(
  parameter  int unsigned Width  = 128,
  parameter  int unsigned Depth  = 4,
  localparam int unsigned AddrW  = $clog2(Depth),
  localparam int unsigned LevelW = AddrW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [Width-1:0]  wdata,
  input  logic              pop,
  output logic [Width-1:0]  rdata,
  output logic [Width-1:0]  rdata_next,
  output logic              full,
  output logic              empty,
  output logic [LevelW-1:0] level
);

  logic [Width-1:0]  mem [Depth];
  logic [AddrW-1:0]  wr_ptr;
  logic [AddrW-1:0]  rd_ptr;
  logic [AddrW-1:0]  rd_ptr_next;
  logic [LevelW-1:0] level_q;

  // Depth is a power of two, so pointers wrap by plain overflow.
  assign rd_ptr_next = rd_ptr + 1'b1;

  // NOTE: storage is deliberately not reset; level_q guards every read, so
  // clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_next;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata      = mem[rd_ptr];
  assign rdata_next = mem[rd_ptr_next];
  assign level      = level_q;
  assign full       = (level_q == LevelW'(Depth));
  assign empty      = (level_q == '0);

endmodule

// File: rtl/cve2_rvfi_trace_packer.sv
// ----------------------------------------------------------------------------
// cve2_rvfi_trace_packer
//   Captures every retired instruction from the RVFI port into a record FIFO
//   and streams each record as a 4-beat packet (HDR, PC, INSN, WDATA) on a
//   32-bit valid/ready interface. Records arriving while the FIFO is full are
//   dropped; the loss is counted in a saturating total and reported in the
//   header of the next record that is captured.
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   trace_en_i          capture enable (queued records still drain when low)
//   rvfi_*              retirement port of the core
//   trace_valid_o/ready handshake of the outgoing beat stream
//   trace_data_o        beat payload, registered
//   trace_last_o        marks the WDATA beat
//   fifo_level_o        records held, including the one being sent
//   drop_total_o        saturating count of dropped records
// ----------------------------------------------------------------------------
module cve2_rvfi_trace_packer
  import cve2_rvfi_trace_packer_pkg::*;
#(
  parameter  int unsigned Depth    = 4,
  parameter  int unsigned DropCntW = 16,
  localparam int unsigned LevelW   = $clog2(Depth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                trace_en_i,
  input  logic                rvfi_valid,
  input  logic [63:0]         rvfi_order,
  input  logic [31:0]         rvfi_insn,
  input  logic                rvfi_trap,
  input  logic                rvfi_halt,
  input  logic                rvfi_intr,
  input  logic [1:0]          rvfi_mode,
  input  logic [4:0]          rvfi_rd_addr,
  input  logic [31:0]         rvfi_rd_wdata,
  input  logic [31:0]         rvfi_pc_rdata,
  output logic                trace_valid_o,
  input  logic                trace_ready_i,
  output logic [31:0]         trace_data_o,
  output logic                trace_last_o,
  output logic [LevelW-1:0]   fifo_level_o,
  output logic [DropCntW-1:0] drop_total_o
);

  // Only the low half-word of the retirement index is packed.
  logic unused_order_hi;
  assign unused_order_hi = ^rvfi_order[63:16];

  // --------------------------------------------------------------------------
  // Capture side
  // --------------------------------------------------------------------------
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LevelW-1:0]    fifo_level;
  trace_rec_t           head_rec;
  trace_rec_t           head_next_rec;
  trace_rec_t           in_rec;
  logic                 capture;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic [DropPendW-1:0] drop_pend_q;
  logic [DropCntW-1:0]  drop_total_q;

  trace_beat_e          state_q;
  trace_beat_e          state_d;
  logic                 beat_hs;

  assign capture = rvfi_valid & trace_en_i;
  // A full FIFO still accepts when the WDATA handshake frees a slot this cycle.
  assign push    = capture & (~fifo_full | pop);
  assign drop    = capture & fifo_full & ~pop;

  always_comb begin
    in_rec.hdr.trap      = rvfi_trap;
    in_rec.hdr.intr      = rvfi_intr;
    in_rec.hdr.halt      = rvfi_halt;
    in_rec.hdr.ovf       = (drop_pend_q != '0);
    in_rec.hdr.rd_addr   = rvfi_rd_addr;
    in_rec.hdr.mode      = rvfi_mode;
    in_rec.hdr.drop_pend = drop_pend_q;
    in_rec.hdr.order     = rvfi_order[15:0];
    in_rec.pc            = rvfi_pc_rdata;
    in_rec.insn          = rvfi_insn;
    in_rec.wdata         = rvfi_rd_wdata;
  end

  // Pending drops are handed to the next captured header and then cleared;
  // push and drop are mutually exclusive, so no count is lost in between.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_pend_q  <= '0;
      drop_total_q <= '0;
    end else begin
      if (push) begin
        drop_pend_q <= '0;
      end else if (drop && (drop_pend_q != '1)) begin
        drop_pend_q <= drop_pend_q + 1'b1;
      end
      if (drop && (drop_total_q != '1)) begin
        drop_total_q <= drop_total_q + 1'b1;
      end
    end
  end

  cve2_trace_fifo #(
    .Width ($bits(trace_rec_t)),
    .Depth (Depth)
  ) u_fifo (
    .clk        (clk_i),
    .rst        (rst_i),
    .push       (push),
    .wdata      (in_rec),
    .pop        (pop),
    .rdata      (head_rec),
    .rdata_next (head_next_rec),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  // --------------------------------------------------------------------------
  // Beat FSM and registered output stage
  // --------------------------------------------------------------------------
  // The output register is loaded with the beat for state_d, so the record
  // feeding it must be the one that will be at the head after this edge:
  // the incoming record when the FIFO is (about to be) empty, the entry
  // behind the head when the current record pops, otherwise the head itself.
  logic        valid_q;
  logic        last_q;
  logic [31:0] data_q;
  trace_rec_t  src_rec;

  assign beat_hs = valid_q & trace_ready_i;
  assign pop     = (state_q == WDATA) & beat_hs;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    src_rec = head_rec;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = HDR;
        end else if (push) begin
          state_d = HDR;
          src_rec = in_rec;
        end
      end
      HDR:  if (beat_hs) state_d = PC;
      PC:   if (beat_hs) state_d = INSN;
      INSN: if (beat_hs) state_d = WDATA;
      WDATA: begin
        if (beat_hs) begin
          if (fifo_level > LevelW'(1)) begin
            state_d = HDR;
            src_rec = head_next_rec;
          end else if (push) begin
            state_d = HDR;
            src_rec = in_rec;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d != IDLE);
      last_q  <= (state_d == WDATA);
      data_q  <= beat_word(src_rec, state_d);
    end
  end

  assign trace_valid_o = valid_q;
  assign trace_last_o  = last_q;
  assign trace_data_o  = data_q;
  assign fifo_level_o  = fifo_level;
  assign drop_total_o  = drop_total_q;

endmodule
